// File: rtl/cpu15_pkg.sv
// cpu15_pkg
// Purpose: declarations shared by the phase controller and its stall
// watchdog. It holds the enumerated phase states, the default watchdog
// limit, and the width of the watchdog's stall counter.
// Ports: none (package).

package cpu15_pkg;

   // Instruction phase states. The 3-bit encoding is fixed here so that
   // every block that imports this package decodes the states the same way.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FT     = 3'd1,
      ST_DC     = 3'd2,
      ST_EX     = 3'd3,
      ST_WB     = 3'd4,
      ST_HALTED = 3'd5
   } phase_state_t;

   // Default number of consecutive stalled EX cycles that trip the watchdog.
   localparam int STALL_MAX_DEFAULT = 15;

   // The watchdog limit may be at most 255, so an 8-bit counter is enough.
   localparam int STALL_CNT_W = 8;

endpackage

// File: rtl/stall_wdt.sv
// stall_wdt
// Purpose: counts consecutive stalled EX cycles. It raises trip during the
// cycle that would be the STALL_MAX-th consecutive stalled cycle, so that
// the controller can leave EX on that same clock edge.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - synchronous active-low reset
//   count_en - this cycle is in EX with the stall input high
//   clear    - this cycle breaks the stall run (not in EX, or no stall)
//   trip     - the stall limit is reached this cycle

module stall_wdt
   import cpu15_pkg::*;
#(
   parameter int STALL_MAX = STALL_MAX_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic count_en,
   input  logic clear,
   output logic trip
);

   localparam logic [STALL_CNT_W-1:0] TRIP_AT = STALL_CNT_W'(STALL_MAX - 1);

   logic [STALL_CNT_W-1:0] stall_cnt;

   // The count holds the number of stalled cycles already seen. A trip
   // happens when the current cycle would bring the count to STALL_MAX.
   assign trip = count_en && !clear && (stall_cnt == TRIP_AT);

   // Clear takes priority over counting. The count freezes once it trips,
   // because the controller leaves EX on the tripping edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stall_cnt <= '0;
      end else if (clear) begin
         stall_cnt <= '0;
      end else if (count_en && !trip) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: rtl/phase_ctrl.sv
// phase_ctrl
// Purpose: sequences a 4-phase instruction cycle (FT, DC, EX, WB). It
// supports free-run and single-step modes, a HALT instruction, and a
// watchdog on stalls in EX. The machine is Moore: every output is either
// a register or a decode of the state register.
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - synchronous active-low reset
//   run        - level, free-run request
//   step       - pulse, execute one instruction
//   stall      - level, hold the EX phase
//   halt_req   - HALT decoded; only sampled while in DC
//   en_ft/en_dc/en_ex/en_wb - one-hot phase enables
//   running    - high in FT, DC, EX and WB
//   halted     - high in the HALTED state
//   instr_done - one-cycle pulse after each WB exit
//   stall_err  - sticky flag, set when the watchdog trips
//   instr_cnt  - retired instruction count, wraps

module phase_ctrl
   import cpu15_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int STALL_MAX = STALL_MAX_DEFAULT
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             run,
   input  logic             step,
   input  logic             stall,
   input  logic             halt_req,
   output logic             en_ft,
   output logic             en_dc,
   output logic             en_ex,
   output logic             en_wb,
   output logic             running,
   output logic             halted,
   output logic             instr_done,
   output logic             stall_err,
   output logic [CNT_W-1:0] instr_cnt
);

   phase_state_t     state, state_next;
   logic             step_mode, step_mode_next;
   logic             halt_pend, halt_pend_next;
   logic             done_next;
   logic             stall_err_next;
   logic [CNT_W-1:0] cnt_next;
   logic             wdt_count, wdt_trip;

   // The watchdog counts only while EX is stalled. Any other cycle
   // clears it, so only consecutive stalls accumulate.
   assign wdt_count = (state == ST_EX) && stall;

   stall_wdt #(
      .STALL_MAX (STALL_MAX)
   ) u_wdt (
      .clk      (clk),
      .reset_n  (reset_n),
      .count_en (wdt_count),
      .clear    (!wdt_count),
      .trip     (wdt_trip)
   );

   // State and status registers. Reset overrides every input in every state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= ST_IDLE;
         step_mode  <= 1'b0;
         halt_pend  <= 1'b0;
         instr_done <= 1'b0;
         stall_err  <= 1'b0;
         instr_cnt  <= '0;
      end else begin
         state      <= state_next;
         step_mode  <= step_mode_next;
         halt_pend  <= halt_pend_next;
         instr_done <= done_next;
         stall_err  <= stall_err_next;
         instr_cnt  <= cnt_next;
      end
   end

   // Next-state logic. The WB exit produces the done pulse and the count
   // increment, and these become visible together on the following cycle.
   // A watchdog trip leaves EX directly for HALTED, with no WB, no done
   // pulse and no count increment.
   always_comb begin
      state_next     = state;
      step_mode_next = step_mode;
      halt_pend_next = halt_pend;
      done_next      = 1'b0;
      stall_err_next = stall_err;
      cnt_next       = instr_cnt;
      case (state)
         ST_IDLE: begin
            if (run) begin
               state_next     = ST_FT;
               step_mode_next = 1'b0;
            end else if (step) begin
               state_next     = ST_FT;
               step_mode_next = 1'b1;
            end
         end
         ST_FT: begin
            state_next = ST_DC;
         end
         ST_DC: begin
            if (halt_req) begin
               halt_pend_next = 1'b1;
            end
            state_next = ST_EX;
         end
         ST_EX: begin
            if (wdt_trip) begin
               state_next     = ST_HALTED;
               stall_err_next = 1'b1;
            end else if (!stall) begin
               state_next = ST_WB;
            end
         end
         ST_WB: begin
            done_next = 1'b1;
            cnt_next  = instr_cnt + CNT_W'(1);
            if (halt_pend) begin
               state_next = ST_HALTED;
            end else if (step_mode || !run) begin
               state_next = ST_IDLE;
            end else begin
               state_next = ST_FT;
            end
         end
         ST_HALTED: begin
            state_next = ST_HALTED;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // These outputs are decoded from the state register only.
   assign en_ft   = (state == ST_FT);
   assign en_dc   = (state == ST_DC);
   assign en_ex   = (state == ST_EX);
   assign en_wb   = (state == ST_WB);
   assign running = en_ft || en_dc || en_ex || en_wb;
   assign halted  = (state == ST_HALTED);

endmodule

// File: tb/tb_phase_ctrl.sv
// tb_phase_ctrl
// Purpose: self-checking bench for phase_ctrl. It runs two instances on
// the same inputs: one with the default 16-bit counter and one with a
// 4-bit counter to exercise wrap-around. The bench has three parts: a
// table of hand-derived vectors, directed multi-cycle sequences, and a
// randomized run checked against a behavioural model.
// Ports: none.

module tb_phase_ctrl;

   localparam int STALL_LIMIT = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, run, step, stall, halt_req;

   logic a_ft, a_dc, a_ex, a_wb, a_running, a_halted, a_done, a_err;
   logic [15:0] a_cnt;
   logic b_ft, b_dc, b_ex, b_wb, b_running, b_halted, b_done, b_err;
   logic [3:0] b_cnt;

   int checks = 0;
   int failures = 0;

   phase_ctrl dut_a (
      .clk(clk), .reset_n(reset_n), .run(run), .step(step), .stall(stall),
      .halt_req(halt_req), .en_ft(a_ft), .en_dc(a_dc), .en_ex(a_ex),
      .en_wb(a_wb), .running(a_running), .halted(a_halted),
      .instr_done(a_done), .stall_err(a_err), .instr_cnt(a_cnt)
   );

   phase_ctrl #(.CNT_W(4)) dut_b (
      .clk(clk), .reset_n(reset_n), .run(run), .step(step), .stall(stall),
      .halt_req(halt_req), .en_ft(b_ft), .en_dc(b_dc), .en_ex(b_ex),
      .en_wb(b_wb), .running(b_running), .halted(b_halted),
      .instr_done(b_done), .stall_err(b_err), .instr_cnt(b_cnt)
   );

   // Output bundle order: {ft, dc, ex, wb, running, halted, done, err}
   localparam logic [7:0] O_IDLE   = 8'b0000_0000;
   localparam logic [7:0] O_IDLE_D = 8'b0000_0010;
   localparam logic [7:0] O_FT     = 8'b1000_1000;
   localparam logic [7:0] O_FT_D   = 8'b1000_1010;
   localparam logic [7:0] O_DC     = 8'b0100_1000;
   localparam logic [7:0] O_EX     = 8'b0010_1000;
   localparam logic [7:0] O_WB     = 8'b0001_1000;
   localparam logic [7:0] O_HALT   = 8'b0000_0100;
   localparam logic [7:0] O_HALT_D = 8'b0000_0110;
   localparam logic [7:0] O_HALT_E = 8'b0000_0101;

   function automatic logic [7:0] packA();
      return {a_ft, a_dc, a_ex, a_wb, a_running, a_halted, a_done, a_err};
   endfunction

   function automatic logic [7:0] packB();
      return {b_ft, b_dc, b_ex, b_wb, b_running, b_halted, b_done, b_err};
   endfunction

   // Behavioural reference: an instruction is either in progress (with a
   // phase index 0..3), idle, or the machine is halted for good.
   bit m_active, m_halted, m_step, m_hpend, m_done, m_err;
   int m_phase, m_stallrun, m_cnt;

   task automatic modelStep();
      if (!reset_n) begin
         m_active = 0; m_halted = 0; m_step = 0; m_hpend = 0;
         m_done = 0; m_err = 0; m_phase = 0; m_stallrun = 0; m_cnt = 0;
      end else begin
         m_done = 0;
         if (m_halted) begin
            m_active = 0;
         end else if (!m_active) begin
            if (run || step) begin
               m_active = 1;
               m_phase = 0;
               m_step = !run;
            end
         end else if (m_phase == 0) begin
            m_phase = 1;
         end else if (m_phase == 1) begin
            if (halt_req) m_hpend = 1;
            m_phase = 2;
         end else if (m_phase == 2) begin
            if (stall) begin
               m_stallrun++;
               if (m_stallrun == STALL_LIMIT) begin
                  m_err = 1; m_halted = 1; m_active = 0; m_stallrun = 0;
               end
            end else begin
               m_stallrun = 0;
               m_phase = 3;
            end
         end else begin
            m_done = 1;
            m_cnt++;
            if (m_hpend) begin
               m_halted = 1; m_active = 0;
            end else if (m_step || !run) begin
               m_active = 0;
            end else begin
               m_phase = 0;
            end
         end
      end
   endtask

   function automatic logic [7:0] modelOut();
      return {m_active && m_phase == 0, m_active && m_phase == 1,
              m_active && m_phase == 2, m_active && m_phase == 3,
              m_active, m_halted, m_done, m_err};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rn, input logic r, input logic s,
                                input logic st, input logic h);
      reset_n = rn; run = r; step = s; stall = st; halt_req = h;
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, 0, 0);
      tick();
      applyStimulus(1, 0, 0, 0, 0);
   endtask

   typedef struct {
      logic       rn, r, s, st, h;
      logic [7:0] exp_o;
      int         exp_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic addVec(input logic rn, input logic r, input logic s, input logic st,
                         input logic h, input logic [7:0] o, input int c);
      vec_t v;
      v.rn = rn; v.r = r; v.s = s; v.st = st; v.h = h; v.exp_o = o; v.exp_cnt = c;
      vecs.push_back(v);
   endtask

   initial begin
      applyStimulus(0, 0, 0, 0, 0);

      // Table: a single step, a stalled run instruction, HALT_REQ outside
      // and inside DC, halt persistence, reset priority, and mode priority.
      addVec(0,0,0,0,0, O_IDLE,   0);
      addVec(1,0,0,0,0, O_IDLE,   0);
      addVec(1,0,1,0,0, O_FT,     0);
      addVec(1,0,0,0,0, O_DC,     0);
      addVec(1,0,1,0,0, O_EX,     0);
      addVec(1,0,0,0,0, O_WB,     0);
      addVec(1,0,0,0,0, O_IDLE_D, 1);
      addVec(1,0,0,0,0, O_IDLE,   1);
      addVec(1,1,0,0,0, O_FT,     1);
      addVec(1,1,0,0,0, O_DC,     1);
      addVec(1,0,0,0,0, O_EX,     1);
      addVec(1,0,0,1,0, O_EX,     1);
      addVec(1,0,0,1,0, O_EX,     1);
      addVec(1,0,0,1,0, O_EX,     1);
      addVec(1,0,0,0,0, O_WB,     1);
      addVec(1,1,0,0,0, O_FT_D,   2);
      addVec(1,1,0,0,1, O_DC,     2);
      addVec(1,1,0,0,0, O_EX,     2);
      addVec(1,1,0,0,1, O_WB,     2);
      addVec(1,1,0,0,0, O_FT_D,   3);
      addVec(1,1,0,0,0, O_DC,     3);
      addVec(1,1,0,0,1, O_EX,     3);
      addVec(1,1,0,0,0, O_WB,     3);
      addVec(1,1,0,0,0, O_HALT_D, 4);
      addVec(1,1,1,0,0, O_HALT,   4);
      addVec(1,1,1,1,1, O_HALT,   4);
      addVec(0,1,1,0,0, O_IDLE,   0);
      addVec(1,1,1,0,0, O_FT,     0);
      addVec(1,0,0,0,0, O_DC,     0);
      addVec(1,0,0,0,0, O_EX,     0);
      addVec(1,1,0,0,0, O_WB,     0);
      addVec(1,1,0,0,0, O_FT_D,   1);
      addVec(1,0,0,0,0, O_DC,     1);
      addVec(1,0,0,0,0, O_EX,     1);
      addVec(1,0,0,0,0, O_WB,     1);
      addVec(1,0,0,0,0, O_IDLE_D, 2);
      addVec(1,0,1,0,0, O_FT,     2);
      addVec(1,1,0,0,0, O_DC,     2);
      addVec(1,1,0,0,0, O_EX,     2);
      addVec(1,1,0,0,0, O_WB,     2);
      addVec(1,1,0,0,0, O_IDLE_D, 3);
      addVec(1,1,0,0,0, O_FT,     3);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rn, vecs[i].r, vecs[i].s, vecs[i].st, vecs[i].h);
         tick();
         checkOutput($sformatf("vec%0d_out", i), {24'd0, packA()}, {24'd0, vecs[i].exp_o});
         checkOutput($sformatf("vec%0d_cnt", i), {16'd0, a_cnt}, vecs[i].exp_cnt);
         checkOutput($sformatf("vec%0d_cnt4", i), {28'd0, b_cnt}, vecs[i].exp_cnt % 16);
      end

      // Free run with no stalls: phases rotate with period 4, and there is
      // one done pulse per instruction.
      doReset();
      applyStimulus(1, 1, 0, 0, 0);
      for (int k = 1; k <= 13; k++) begin
         logic [7:0] e;
         tick();
         case ((k - 1) % 4)
            0: e = (k > 1) ? O_FT_D : O_FT;
            1: e = O_DC;
            2: e = O_EX;
            default: e = O_WB;
         endcase
         checkOutput($sformatf("freerun_k%0d", k), {24'd0, packA()}, {24'd0, e});
      end
      checkOutput("freerun_cnt", {16'd0, a_cnt}, 32'd3);

      // Watchdog boundary: 14 stalled EX cycles still reach WB.
      doReset();
      applyStimulus(1, 1, 0, 1, 0);
      for (int k = 1; k <= 17; k++) tick();
      checkOutput("wdt14_in_ex", {24'd0, packA()}, {24'd0, O_EX});
      applyStimulus(1, 1, 0, 0, 0);
      tick();
      checkOutput("wdt14_wb", {24'd0, packA()}, {24'd0, O_WB});

      // Watchdog trip: the 15th stalled EX cycle goes straight to HALTED.
      doReset();
      applyStimulus(1, 1, 0, 1, 0);
      for (int k = 1; k <= 17; k++) tick();
      checkOutput("wdt15_pre", {24'd0, packA()}, {24'd0, O_EX});
      tick();
      checkOutput("wdt15_trip", {24'd0, packA()}, {24'd0, O_HALT_E});
      checkOutput("wdt15_cnt", {16'd0, a_cnt}, 32'd0);
      applyStimulus(1, 1, 1, 0, 0);
      tick();
      checkOutput("wdt15_sticky", {24'd0, packA()}, {24'd0, O_HALT_E});

      // Reset in the middle of EX returns everything to zero, and the
      // first state decision is made on the edge after release.
      doReset();
      applyStimulus(1, 1, 0, 0, 0);
      for (int k = 1; k <= 3; k++) tick();
      checkOutput("midex_ex", {24'd0, packA()}, {24'd0, O_EX});
      applyStimulus(0, 1, 0, 0, 0);
      tick();
      checkOutput("midex_rst", {8'd0, packA(), a_cnt}, 32'd0);
      applyStimulus(1, 0, 0, 0, 0);
      tick();
      checkOutput("midex_idle", {24'd0, packA()}, {24'd0, O_IDLE});

      // Counter wrap in the 4-bit instance across 17 instructions.
      doReset();
      applyStimulus(1, 1, 0, 0, 0);
      for (int k = 1; k <= 69; k++) begin
         tick();
         if (k == 61) checkOutput("wrap_15", {28'd0, b_cnt}, 32'd15);
         if (k == 65) checkOutput("wrap_0", {28'd0, b_cnt}, 32'd0);
      end
      checkOutput("wrap_1", {28'd0, b_cnt}, 32'd1);
      checkOutput("wrap_wide17", {16'd0, a_cnt}, 32'd17);

      // Randomized run against the behavioural model.
      applyStimulus(0, 0, 0, 0, 0);
      for (int k = 0; k < 1500; k++) begin
         tick();
         checkOutput($sformatf("rand%0d_a", k), {8'd0, packA(), a_cnt},
                     {8'd0, modelOut(), 16'(m_cnt)});
         checkOutput($sformatf("rand%0d_b", k), {20'd0, packB(), b_cnt},
                     {20'd0, modelOut(), 4'(m_cnt)});
         applyStimulus($urandom_range(0, 99) >= 2,
                       $urandom_range(0, 99) < 70,
                       $urandom_range(0, 99) < 20,
                       $urandom_range(0, 99) < ((k % 200) < 40 ? 97 : 40),
                       $urandom_range(0, 99) < 5);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
